// File: rtl/rx_uart.sv
// rx_uart: oversampling UART receiver, serial_in -> {parity, data} with per-frame error flags.
// Latency: o_valid rises one clk after the stop-bit centre tick (+2 clk when RX_SYNC_EN is defined).
// Backpressure: none; o_valid is a one-clk strobe and the consumer must accept it when it fires.
//
// Ports:
//   clk, reset (async, active-low), sample_tick (OVERSAMPLE x baud enable), serial_in (idles high)
//   o_data {parity, data} LSB = first data bit, o_valid strobe, o_busy frame-in-progress,
//   o_parity_err / o_framing_err describe the most recent frame and hold until the next o_valid.
// Build option: define RX_SYNC_EN to pass serial_in through a 2-flop synchronizer (reset to 1).
module rx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_ODD       = 0,
  parameter int OVERSAMPLE       = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         sample_tick,
  input  logic                                         serial_in,
  output logic [INPUT_DATA_WIDTH+PARITY_ENABLED-1:0]   o_data,
  output logic                                         o_valid,
  output logic                                         o_busy,
  output logic                                         o_parity_err,
  output logic                                         o_framing_err
);

  localparam int NB = INPUT_DATA_WIDTH + PARITY_ENABLED;  // bits between start and stop
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NB + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB - 1);
  localparam logic          PAR_EN    = (PARITY_ENABLED != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Line input, optionally resynchronised. Sync flops reset high so a reset
  // never looks like a falling edge on the idle line.
  logic rx;
`ifdef RX_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], serial_in};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end
  assign rx = sync_q[1];
`else
  assign rx = serial_in;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NB-1:0]   shift_q, shift_d;
  logic [NB-1:0]   data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic [NB-1:0]   rx_at_msb;

  // New bit enters at the top and walks down, so the first bit ends at the LSB.
  always_comb begin
    rx_at_msb         = '0;
    rx_at_msb[NB-1]   = rx;
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    busy_d     = busy_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;  // strobe clears every clk, tick or not

    if (sample_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end

        S_START: begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            if (!rx) begin
              state_d   = S_DATA;
              busy_d    = 1'b1;
              bit_cnt_d = '0;
            end else begin
              // Line was high again at the bit centre: a glitch, not a start bit.
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        S_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = (shift_q >> 1) | rx_at_msb;
            if (bit_cnt_q == BIT_LAST) begin
              state_d   = S_STOP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        S_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            data_d     = shift_q;
            perr_d     = PAR_EN & ((^shift_q) ^ PAR_ODD);
            ferr_d     = ~rx;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
            // A low stop bit may be a break; wait for the line to recover.
            state_d    = rx ? S_IDLE : S_WAIT_HIGH;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          if (rx) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_busy        = busy_q;
  assign o_parity_err  = perr_q;
  assign o_framing_err = ferr_q;

endmodule

// File: tb/tb_rx_uart.sv
// Bench for rx_uart: frames are described at bit level, timed in sample ticks,
// and the expected {parity,data}/error results are queued per frame and
// compared whenever the receiver strobes o_valid.
module tb_rx_uart;
  localparam int DW  = 8;
  localparam int PE  = 1;
  localparam int ODD = 0;
  localparam int OS  = 16;
  localparam int NB  = DW + PE;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic          serial_in;
  logic [NB-1:0] o_data;
  logic          o_valid;
  logic          o_busy;
  logic          o_parity_err;
  logic          o_framing_err;

  rx_uart #(
    .INPUT_DATA_WIDTH(DW),
    .PARITY_ENABLED  (PE),
    .PARITY_ODD      (ODD),
    .OVERSAMPLE      (OS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .serial_in    (serial_in),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_parity_err (o_parity_err),
    .o_framing_err(o_framing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  logic [NB-1:0] exp_data = '0;
  logic          exp_perr = 1'b0;
  logic          exp_ferr = 1'b0;
  logic [NB-1:0] got_data = '0;
  logic          got_perr = 1'b0;
  logic          got_ferr = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            valid_count = 0;
  logic          freeze = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Irregular tick train; frame timing is counted in ticks so gaps don't matter.
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(negedge clk);
      sample_tick = freeze ? 1'b0 : ($urandom_range(0, 1) == 1);
    end
  end

  // Output checker: every cycle, either reset values, a frame result, or held values.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check("rst_data", 32'(o_data), 0);
      check("rst_valid", 32'(o_valid), 0);
      check("rst_busy", 32'(o_busy), 0);
      check("rst_perr", 32'(o_parity_err), 0);
      check("rst_ferr", 32'(o_framing_err), 0);
    end else if (o_valid) begin
      valid_count++;
      got_data = o_data;
      got_perr = o_parity_err;
      got_ferr = o_framing_err;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got data=%0h want no frame", o_data);
      end else begin
        cur = exp_q.pop_front();
        check("frame_data", 32'(o_data), 32'(cur.data));
        check("frame_perr", 32'(o_parity_err), 32'(cur.perr));
        check("frame_ferr", 32'(o_framing_err), 32'(cur.ferr));
        exp_data = cur.data;
        exp_perr = cur.perr;
        exp_ferr = cur.ferr;
      end
    end else begin
      check("hold_data", 32'(o_data), 32'(exp_data));
      check("hold_perr", 32'(o_parity_err), 32'(exp_perr));
      check("hold_ferr", 32'(o_framing_err), 32'(exp_ferr));
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(posedge clk);
        guard++;
        if (guard > 2000) begin
          errors++;
          $display("FAIL tick_timeout got=%0d clks want<=2000", guard);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "tick generator stalled");
        end
      end while (!sample_tick);
    end
  endtask

  task automatic drive(input logic b);
    @(negedge clk);
    serial_in = b;
  endtask

  // One frame: start, data LSB first, parity, stop. freeze_bit >= 0 stalls
  // the tick train for a while in the middle of that bit position.
  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                            input int freeze_bit);
    logic [NB+1:0] bits;
    exp_t e;
    check("frame_lost", 32'(exp_q.size()), 0);
    e.data = {par, d};
    e.perr = (^{par, d}) ^ (ODD != 0);
    e.ferr = ~stop;
    exp_q.push_back(e);
    bits = {stop, par, d, 1'b0};
    for (int k = 0; k < NB + 2; k++) begin
      drive(bits[k]);
      if (k == 1) begin
        wait_ticks(OS / 2);
        #1 check("busy_mid_frame", 32'(o_busy), 1);
        wait_ticks(OS / 2);
      end else if (k == freeze_bit) begin
        wait_ticks(OS / 2);
        freeze = 1'b1;
        repeat (40) @(posedge clk);
        #1 check("busy_frozen", 32'(o_busy), 1);
        freeze = 1'b0;
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
    #1 check("busy_after_stop", 32'(o_busy), 0);
  endtask

  initial begin
    int vc;
    logic [DW-1:0] d;
    logic par, stop;
    int gap;

    reset = 1'b0;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    wait_ticks(20);

    // Clean frame 0xA5, even parity bit 0.
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    check("a5_data", 32'(got_data), 32'h0A5);
    check("a5_perr", 32'(got_perr), 0);
    check("a5_ferr", 32'(got_ferr), 0);

    // 0x07 with a wrong (even) parity bit.
    send_frame(8'h07, 1'b0, 1'b1, -1);
    check("p07_data", 32'(got_data), 32'h007);
    check("p07_perr", 32'(got_perr), 1);
    check("p07_ferr", 32'(got_ferr), 0);

    // Framing error followed by a long break.
    vc = valid_count;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    wait_ticks(40 * OS);
    #1;
    check("brk_valid_once", 32'(valid_count - vc), 1);
    check("brk_busy", 32'(o_busy), 0);
    check("brk_data", 32'(got_data), 32'h03C);
    check("brk_ferr", 32'(got_ferr), 1);
    drive(1'b1);
    wait_ticks(OS);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    check("after_brk_data", 32'(got_data), 32'h055);
    check("after_brk_ferr", 32'(got_ferr), 0);

    // Start glitch: 4 ticks low is rejected.
    vc = valid_count;
    drive(1'b0);
    wait_ticks(4);
    #1 check("glitch_busy_low", 32'(o_busy), 0);
    drive(1'b1);
    wait_ticks(2 * OS);
    #1;
    check("glitch_busy", 32'(o_busy), 0);
    check("glitch_no_valid", 32'(valid_count - vc), 0);

    // Reset in the middle of bit 3 of 0xFF.
    drive(1'b0);
    wait_ticks(OS);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1);
      wait_ticks(OS);
    end
    drive(1'b1);
    wait_ticks(OS / 2);
    @(negedge clk);
    reset = 1'b0;
    exp_data = '0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    exp_q.delete();
    #1;
    check("arst_data", 32'(o_data), 0);
    check("arst_busy", 32'(o_busy), 0);
    check("arst_valid", 32'(o_valid), 0);
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    wait_ticks(2 * OS);
    send_frame(8'h81, 1'b0, 1'b1, -1);
    check("r81_data", 32'(got_data), 32'h081);

    // Back-to-back frames.
    vc = valid_count;
    send_frame(8'h12, 1'b0, 1'b1, -1);
    check("b2b_first", 32'(got_data), 32'h012);
    send_frame(8'h34, 1'b1, 1'b1, -1);
    check("b2b_second", 32'(got_data), 32'h134);
    check("b2b_count", 32'(valid_count - vc), 2);
    check("b2b_perr", 32'(got_perr), 0);

    // Tick train frozen mid-frame.
    send_frame(8'hC3, 1'b0, 1'b1, 5);
    check("frz_data", 32'(got_data), 32'h0C3);

    // Random frames: mostly good parity and stop, random gaps incl. back-to-back.
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      par  = (^d) ^ (ODD != 0);
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop = ($urandom_range(0, 6) != 0);
      send_frame(d, par, stop, ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, NB)) : -1);
      if (!stop) begin
        wait_ticks($urandom_range(0, 2 * OS));
        drive(1'b1);
        wait_ticks(4);
      end
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      if (gap > 0) wait_ticks(gap);
    end

    wait_ticks(2 * OS);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
